// File: rtl/dec_scan_nx.sv
// dec_scan_nx: SEL_W-to-2^SEL_W one-hot decoder with registered outputs and
// an auto-scan mode that walks the one-hot bit across every position, holding
// each position for DWELL cycles.
//
// Optional build macro: DEC_SCAN_BLANK_EN
//   When defined, scan mode inserts one all-zero cycle at every index advance
//   to suppress ghosting on the driven rows. The position period becomes
//   DWELL+1 cycles. Direct mode and scan loads never blank.
//   When undefined (default), the position period is DWELL cycles.
module dec_scan_nx #(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  load,
    output logic [2**SEL_W-1:0]   out,
    output logic [SEL_W-1:0]      cur_idx,
    output logic                  wrap
);

    localparam int OUT_W = 2 ** SEL_W;

    // Counter only needs to reach DWELL-1; keep at least one bit so DWELL=1
    // still yields a legal vector (it then always sits at its last value).
    localparam int                 CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]   DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]   IDX_LAST   = {SEL_W{1'b1}};

    // Registered state
    logic [OUT_W-1:0] out_reg;
    logic [SEL_W-1:0] idx_reg;
    logic [CNT_W-1:0] dwell_reg;
    logic             wrap_reg;
    logic             mode_q;

    // Next-state values
    logic [OUT_W-1:0] out_next;
    logic [SEL_W-1:0] idx_next;
    logic [CNT_W-1:0] dwell_next;
    logic             wrap_next;
    logic             show_next;

`ifdef DEC_SCAN_BLANK_EN
    // Set during the blank cycle that follows an index advance.
    logic             blank_reg;
    logic             blank_next;
`endif

    // Next-state selection: enable, direct decode, load, scan entry and the
    // dwell/advance sequence, in priority order.
    always_comb begin
        idx_next   = idx_reg;
        dwell_next = dwell_reg;
        wrap_next  = 1'b0;
        show_next  = 1'b0;
`ifdef DEC_SCAN_BLANK_EN
        blank_next = blank_reg;
`endif
        // en_n=1 leaves everything frozen and blanks the output.
        if (!en_n) begin
            if (!mode) begin
                // Direct decode: follow sel, keep the scan counter parked.
                idx_next   = sel;
                dwell_next = '0;
                show_next  = 1'b1;
`ifdef DEC_SCAN_BLANK_EN
                blank_next = 1'b0;
`endif
            end else if (load) begin
                // Load wins over dwell expiry and also over scan entry (entry
                // would only clear the counter, which load does anyway).
                idx_next   = sel;
                dwell_next = '0;
                show_next  = 1'b1;
`ifdef DEC_SCAN_BLANK_EN
                blank_next = 1'b0;
`endif
            end else if (!mode_q) begin
                // Scan entry: start at the current index with a fresh dwell,
                // so the output does not change on the switch-over.
                dwell_next = '0;
                show_next  = 1'b1;
`ifdef DEC_SCAN_BLANK_EN
                blank_next = 1'b0;
`endif
            end
`ifdef DEC_SCAN_BLANK_EN
            else if (blank_reg) begin
                // End of blank cycle: reveal the index chosen last cycle.
                dwell_next = '0;
                show_next  = 1'b1;
                blank_next = 1'b0;
            end
`endif
            else if (dwell_reg == DWELL_LAST) begin
                // Dwell expired: step to the next position.
                idx_next   = idx_reg + 1'b1;
                dwell_next = '0;
                wrap_next  = (idx_reg == IDX_LAST);
`ifdef DEC_SCAN_BLANK_EN
                show_next  = 1'b0;
                blank_next = 1'b1;
`else
                show_next  = 1'b1;
`endif
            end else begin
                dwell_next = dwell_reg + 1'b1;
                show_next  = 1'b1;
            end
        end
    end

    // One-hot decode of the next index; a single comparator per output bit
    // guarantees at most one bit can ever be set.
    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_dec
            assign out_next[gi] = show_next && (idx_next == SEL_W'(gi));
        end
    endgenerate

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg   <= '0;
            idx_reg   <= '0;
            dwell_reg <= '0;
            wrap_reg  <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            out_reg   <= out_next;
            idx_reg   <= idx_next;
            dwell_reg <= dwell_next;
            wrap_reg  <= wrap_next;
            mode_q    <= mode;
        end
    end

`ifdef DEC_SCAN_BLANK_EN
    // Blank-cycle flag, reset alongside the rest of the scan state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_reg <= 1'b0;
        end else begin
            blank_reg <= blank_next;
        end
    end
`endif

    assign out     = out_reg;
    assign cur_idx = idx_reg;
    assign wrap    = wrap_reg;

endmodule

// File: tb/tb_dec_scan_nx.sv
// Testbench for dec_scan_nx (default build, SEL_W=2, DWELL=4): directed
// stimulus, a cycle-by-cycle behavioural model compared every falling edge,
// and literal expectations on key points of each scenario.
module tb_dec_scan_nx;

    localparam int SEL_W = 2;
    localparam int DWELL = 4;
    localparam int OUT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             en_n;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic             load;
    logic [OUT_W-1:0] out;
    logic [SEL_W-1:0] cur_idx;
    logic             wrap;

    int n_checks = 0;
    int n_fail   = 0;
    bit compare_on = 0;

    dec_scan_nx #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_n    (en_n),
        .mode    (mode),
        .sel     (sel),
        .load    (load),
        .out     (out),
        .cur_idx (cur_idx),
        .wrap    (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a position index plus the number of cycles the
    // current position has been on display ("age"). Each scan edge either
    // restarts the position (entry/load), ages it, or moves on when it has
    // been shown DWELL times.
    int          m_idx, m_age;
    bit          m_mode_q, m_wrap;
    logic [3:0]  m_out;

    always @(posedge clk or negedge rst_n) begin
        int idx, age;
        bit w;
        logic [3:0] o;
        if (!rst_n) begin
            m_idx    <= 0;
            m_age    <= 1;
            m_mode_q <= 0;
            m_out    <= '0;
            m_wrap   <= 0;
        end else begin
            idx = m_idx;
            age = m_age;
            w   = 0;
            o   = '0;
            if (!en_n) begin
                if (!mode) begin
                    idx = int'(sel);
                    age = 1;
                end else if (load || !m_mode_q) begin
                    if (load) idx = int'(sel);
                    age = 1;
                end else if (age >= DWELL) begin
                    w   = (idx == OUT_W - 1);
                    idx = (idx + 1) % OUT_W;
                    age = 1;
                end else begin
                    age = age + 1;
                end
                o = 4'(1 << idx);
            end
            m_idx    <= idx;
            m_age    <= age;
            m_out    <= o;
            m_wrap   <= w;
            m_mode_q <= mode;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (compare_on) begin
            chk("model_out", int'(out), int'(m_out));
            chk("model_idx", int'(cur_idx), m_idx);
            chk("model_wrap", int'(wrap), int'(m_wrap));
            chk("onehot", ($countones(out) <= 1) ? 1 : 0, 1);
        end
    end

    // Apply inputs at a falling edge and advance to the next falling edge,
    // where the outputs reflect them.
    task automatic cyc(input bit e, input bit m, input int s, input bit l);
        en_n = e;
        mode = m;
        sel  = SEL_W'(s);
        load = l;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        en_n  = 1'b1;
        mode  = 1'b0;
        sel   = '0;
        load  = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        compare_on = 1;
        @(negedge clk);
        chk("reset_out", int'(out), 0);
        chk("reset_idx", int'(cur_idx), 0);
        rst_n = 1'b1;

        // Direct decode
        cyc(0, 0, 2, 0);  chk("direct_sel2", int'(out), 'b0100);
        cyc(0, 0, 3, 0);  chk("direct_sel3", int'(out), 'b1000);

        // Enable blanking
        cyc(0, 0, 1, 0);  chk("blank_pre", int'(out), 'b0010);
        cyc(1, 0, 1, 0);  chk("blank_out", int'(out), 0);
                          chk("blank_idx", int'(cur_idx), 1);
        cyc(0, 0, 1, 0);  chk("blank_post", int'(out), 'b0010);

        // Full scan from index 0
        cyc(0, 0, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            cyc(0, 1, 0, 0);
            chk($sformatf("scan_out_%0d", k), int'(out), 1 << (((k - 1) / 4) % 4));
            chk($sformatf("scan_wrap_%0d", k), int'(wrap), (k == 17) ? 1 : 0);
        end

        // Load with dwell counter at its last value
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0);
        chk("pre_load", int'(out), 'b0001);
        cyc(0, 1, 2, 1);  chk("load_out", int'(out), 'b0100);
                          chk("load_wrap", int'(wrap), 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 0);
            chk("load_hold", int'(out), 'b0100);
        end
        cyc(0, 1, 0, 0);  chk("load_next", int'(out), 'b1000);

        // Freeze at index 1 with dwell at 2
        cyc(0, 1, 1, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            cyc(1, 1, 0, 0);
            chk("freeze_out", int'(out), 0);
            chk("freeze_idx", int'(cur_idx), 1);
        end
        cyc(0, 1, 0, 0);  chk("thaw_out", int'(out), 'b0010);
        cyc(0, 1, 0, 0);  chk("thaw_next", int'(out), 'b0100);

        // Scan exit, then simultaneous entry and load
        cyc(0, 0, 3, 0);  chk("exit_direct", int'(out), 'b1000);
        cyc(0, 0, 0, 0);  chk("direct_sel0", int'(out), 'b0001);
        cyc(0, 1, 2, 1);  chk("entry_load", int'(out), 'b0100);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0);
        chk("entry_hold", int'(out), 'b0100);
        cyc(0, 1, 0, 0);  chk("entry_next", int'(out), 'b1000);

        // Asynchronous reset mid-scan
        cyc(0, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out", int'(out), 0);
        chk("async_idx", int'(cur_idx), 0);
        chk("async_wrap", int'(wrap), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 1, 0, 0);
            chk($sformatf("restart_%0d", k), int'(out), (k <= 4) ? 'b0001 : 'b0010);
        end

        compare_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_scan_nx.md
Name: dec_scan_nx

Overview:
- Parametrised successor to the team's 2x4 negative-enable decoder: SEL_W-to-2^SEL_W one-hot decoder with registered output.
- Adds an auto-scan mode that walks the one-hot output across all positions, holding each for DWELL cycles.
- Used for display/row multiplexing and round-robin strobe generation; sits between control logic and output drivers.

Parameters:
- SEL_W, 2, select width; output width OUT_W = 2**SEL_W (derived localparam, not overridable).
- DWELL, 4, clock cycles each position is held in scan mode; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en_n  input  1  active-low enable; 1 blanks the output and freezes scan counters.
- mode  input  1  0 = direct decode, 1 = auto-scan.
- sel  input  SEL_W  direct-mode select; scan-mode load value.
- load  input  1  scan mode only: jump the scan index to sel.
- out  output  OUT_W  registered one-hot (active-high) output; bit k is asserted for index k.
- cur_idx  output  SEL_W  registered index currently decoded.
- wrap  output  1  one-cycle pulse on scan wrap from OUT_W-1 to 0.

Behaviour:
- Reset (async assert, sync release): out=0, cur_idx=0, wrap=0, dwell counter=0, internal mode_q=0.
- Direct mode (mode=0), en_n=0: out <= 1<<sel and cur_idx <= sel on each edge. Latency is 1 cycle. Dwell counter is held at 0 and wrap is 0.
- Any mode with en_n=1: out <= 0 on the next edge, wrap=0. cur_idx and the dwell counter hold their values.
- Scan mode (mode=1), en_n=0:
  - The dwell counter increments every cycle.
  - When it reaches DWELL-1, it clears and cur_idx <= cur_idx+1 (modulo OUT_W).
  - out <= 1<<(next cur_idx).
  - With DWELL=1, the index advances every cycle.
- Wrap:
  - wrap=1 for exactly the cycle in which cur_idx transitions OUT_W-1 -> 0 due to dwell expiry.
  - A load to 0 does not assert wrap.
- Load (scan mode, en_n=0):
  - cur_idx <= sel, dwell counter <= 0, out <= 1<<sel.
  - Load has priority over simultaneous dwell expiry.
  - Load is ignored in direct mode and when en_n=1.
- Mode entry:
  - mode_q registers mode.
  - On a 0->1 change with en_n=0, scan starts at the current cur_idx with the dwell counter cleared, so there is no output glitch.
  - On a 1->0 change, direct decoding of sel resumes on the next edge.
- Simultaneous mode change and load: mode entry applies first, then the load takes effect in the same cycle.
- out is always one-hot or zero. Two or more bits are never set.
- Reset asserted mid-scan: outputs go to reset values immediately. After release, scan resumes from index 0.

Optional Feature:
- Macro: DEC_SCAN_BLANK_EN.
- Defined:
  - Scan mode inserts one blank cycle (out=0) at each index advance, for ghosting suppression.
  - cur_idx updates in the blank cycle; the new one-hot appears one cycle later.
  - Position period becomes DWELL+1 cycles.
  - wrap pulses in the blank cycle.
  - Load does not insert a blank.
  - Direct mode is unaffected.
- Not defined: no blank cycles; period is DWELL cycles, as described above.

Test Plan:
- Reset/direct: rst_n=0 -> out=0000, cur_idx=0. Release; mode=0, en_n=0, sel=2 -> out=0100 one cycle later. sel=3 -> out=1000 next cycle.
- Enable blanking: direct, sel=1, out=0010. en_n=1 -> out=0000 next edge, cur_idx stays 1. en_n=0 -> out=0010 again.
- Scan sequence (DWELL=4), mode=1 from idx 0:
  - out follows 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001.
  - wrap is high for exactly 1 cycle at the 1000->0001 change.
- Load priority: scan with dwell counter at 3, load=1, sel=2 in the same cycle -> out=0100, dwell restarts, and 0100 holds 4 cycles. No wrap.
- Freeze: scan at idx 1, dwell 2. en_n=1 for 10 cycles -> out=0000. en_n=0 -> out=0010 for the 1 remaining dwell cycle, then 0100.
- DEC_SCAN_BLANK_EN defined, DWELL=2 -> out sequence is 0001,0001,0000,0010,0010,0000,... with wrap in the blank before 0001. Async reset mid-sequence -> out=0000 immediately.
